mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported, variable-latency memory bus between the instruction-fetch (IF) port and the data (MEM-stage) port of the 5-stage MIPS pipeline. It arbitrates round-robin between the two ports and registers the bus request. It holds the request stable until the bus acknowledges, then returns read data with a one-cycle ready pulse. It also drives per-port stall lines that the pipeline controller uses to freeze stages. A watchdog latches a sticky error if the bus never acknowledges.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of ports and bus
- DATA_WIDTH, 32, data width of ports and bus
- TIMEOUT, 255, maximum cycles in a wait state before the error trap; 0 disables the watchdog

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  main clock, rising edge
- rst  input  1  asynchronous active-high reset
- i_req  input  1  IF fetch request; held until i_ready
- i_addr  input  ADDR_WIDTH  fetch address
- i_rdata  output  DATA_WIDTH  fetched word, valid while i_ready=1
- i_ready  output  1  one-cycle completion pulse for IF
- d_ren  input  1  MEM-stage load request
- d_wen  input  1  MEM-stage store request; d_ren and d_wen are never both 1
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  DATA_WIDTH  store data
- d_rdata  output  DATA_WIDTH  load data, valid while d_ready=1
- d_ready  output  1  one-cycle completion pulse for the data port
- if_stall  output  1  combinational: i_req & ~i_ready
- mem_stall  output  1  combinational: (d_ren|d_wen) & ~d_ready
- bus_req  output  1  registered bus request
- bus_we  output  1  registered write strobe, 1 only for stores
- bus_addr  output  ADDR_WIDTH  registered bus address
- bus_wdata  output  DATA_WIDTH  registered bus write data
- bus_ack  input  1  transaction complete; sampled only in wait states
- bus_rdata  input  DATA_WIDTH  read data, valid with bus_ack
- bus_err  output  1  sticky watchdog error

## Operation
- The FSM has six states: IDLE, I_WAIT, D_WAIT, I_DONE, D_DONE and ERR.
- **IDLE:**
  - With exactly one port pending, that port is served.
  - With both ports pending, the port not served last is served. The last-served flag resets to "I", so data wins the first tie.
  - On issue, the block latches addr/wdata/we into the bus registers, sets bus_req=1 and moves to the matching WAIT state.
  - The watchdog counter clears to 0 on issue.
- **I_WAIT / D_WAIT:**
  - bus_req, bus_we, bus_addr and bus_wdata are held constant.
  - The counter increments each cycle without bus_ack.
  - On bus_ack: bus_req←0 and the state moves to I_DONE/D_DONE.
    - Loads: the port rdata register captures bus_rdata.
    - Stores: d_rdata keeps its previous value.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without bus_ack: bus_req←0, bus_err←1 and the state moves to ERR.
- **I_DONE / D_DONE:**
  - The matching *_ready is 1 for exactly this cycle.
  - The last-served flag updates to the served port.
  - No new issue happens here, so the still-asserted request of the completing port is never re-issued.
  - The next state is always IDLE.
- **ERR:** absorbing state. bus_req=0 and both ready outputs are 0, so the pipeline stays stalled. Only rst leaves ERR.
- bus_ack outside the WAIT states is ignored.
- Requesters hold req/addr/wdata stable until ready. Behaviour is undefined if a request drops mid-transaction.
- Counter width is clog2(TIMEOUT+1), with saturating compare.

## Timing
- **Reset values:** state=IDLE, last-served=I, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, i_rdata=0, d_rdata=0, i_ready=0, d_ready=0, bus_err=0, counter=0.
- **Reset response:** reset takes effect asynchronously. bus_req falls immediately, even mid-transaction.
- **Latency:** a request first seen in IDLE at cycle 0 gives bus_req=1 from cycle 1. bus_ack sampled at cycle k≥1 gives ready=1 in cycle k+1. The minimum is ready in cycle 2.
- **Back-to-back:** the earliest next issue is from IDLE in cycle k+2, with bus_req again in cycle k+3. The bus therefore idles for at least 2 cycles between transactions.
- **Stalls:** if_stall and mem_stall are combinational. They are high for every request cycle except the ready cycle.
- **Timeout:** with bus_ack never asserted, bus_err rises TIMEOUT+1 cycles after bus_req rises.

## Test plan
- **Single fetch:** i_req=1, i_addr=0x40; bus_ack=1 two cycles after bus_req rises with bus_rdata=0x2008000A.
  - bus_addr=0x40 and bus_we=0.
  - i_ready pulses one cycle with i_rdata=0x2008000A; if_stall is low only in that cycle.
- **Simultaneous requests from reset:** i_req=1 and d_ren=1 (d_addr=0x100) in the same cycle, zero-wait ack.
  - Data is served first (bus_addr=0x100), then the fetch.
  - d_ready precedes i_ready by 3 cycles.
- **Round-robin:** both ports continuously requesting, each acked immediately.
  - Grants alternate D, I, D, I.
  - Neither port waits for more than one foreign transaction.
- **Store:** d_wen=1, d_addr=0x200, d_wdata=0xDEADBEEF, ack after 5 cycles.
  - bus_we=1 with bus_wdata=0xDEADBEEF held for all 5 cycles.
  - d_ready pulses once; d_rdata is unchanged.
- **Watchdog:** TIMEOUT=8, bus_ack held 0.
  - bus_err=1 nine cycles after bus_req rises; bus_req=0.
  - A later bus_ack and new requests produce no ready.
  - rst clears bus_err.
- **Reset mid-wait:** assert rst during D_WAIT.
  - bus_req=0 asynchronously and all outputs return to reset values.
  - After release, a pending i_req is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory bus
// between the instruction-fetch port and the data port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  if_stall,
  output logic                  mem_stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    I_WAIT,
    D_WAIT,
    I_DONE,
    D_DONE,
    ERR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          last_i;
  logic [CW-1:0] cnt;
  logic          d_pend;
  logic          issue;
  logic          sel_d;
  logic          waiting;
  logic          tmo;

  assign d_pend    = d_ren | d_wen;
  assign waiting   = (state == I_WAIT) || (state == D_WAIT);
  assign i_ready   = (state == I_DONE);
  assign d_ready   = (state == D_DONE);
  assign if_stall  = i_req & ~i_ready;
  assign mem_stall = d_pend & ~d_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    sel_d   = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the port not served last wins.
        if (d_pend && (!i_req || last_i)) begin
          issue   = 1'b1;
          sel_d   = 1'b1;
          state_n = D_WAIT;
        end else if (i_req) begin
          issue   = 1'b1;
          state_n = I_WAIT;
        end
      end
      I_WAIT, D_WAIT: begin
        if (bus_ack) begin
          state_n = (state == I_WAIT) ? I_DONE : D_DONE;
        end else if (TIMEOUT != 0 && cnt == TMAX) begin
          tmo     = 1'b1;
          state_n = ERR;
        end
      end
      I_DONE, D_DONE: state_n = IDLE;
      ERR:            state_n = ERR;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_i    <= 1'b1;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (issue) begin
        bus_req   <= 1'b1;
        bus_we    <= sel_d & d_wen;
        bus_addr  <= sel_d ? d_addr : i_addr;
        bus_wdata <= sel_d ? d_wdata : '0;
        cnt       <= '0;
      end
      if (waiting) begin
        if (bus_ack) begin
          bus_req <= 1'b0;
          if (state == I_WAIT) begin
            i_rdata <= bus_rdata;
          end else if (!bus_we) begin
            d_rdata <= bus_rdata;
          end
        end else if (tmo) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == I_DONE) begin
        last_i <= 1'b1;
      end
      if (state == D_DONE) begin
        last_i <= 1'b0;
      end
    end
  end

endmodule
